// File: rtl/bcd_score_converter.sv
// Binary-to-BCD converter (double dabble, one bit per clock) feeding the number bitmap.
// Ports: clk, resetN (sync, active-high), value/start in; busy, done, digits, overflow, blank out.
// Optional macro BCD_ZERO_BLANK_EN enables the registered leading-zero blanking mask.
module bcd_score_converter #(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic [BIN_W-1:0]      value,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   digits,
    output logic                  overflow,
    output logic [DIGITS-1:0]     blank
);

    // Working BCD register must hold every BIN_W-bit value; 3 bits per digit is always enough.
    localparam int ACC_D = (DIGITS > (BIN_W + 2) / 3) ? DIGITS : (BIN_W + 2) / 3;
    localparam int ACC_W = 4 * ACC_D;
    localparam int DW    = 4 * DIGITS;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0]   MAX_DEC   = pow10(DIGITS) - 64'd1;
    localparam logic [5:0]    LAST      = 6'(BIN_W - 1);
    localparam logic [DW-1:0] ALL_NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t             state;
    logic [BIN_W-1:0]   sh;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   adj;
    logic [5:0]         cnt;
    logic               ovf_r;

    // Add-3 correction on every nibble that would reach 10 or more after the shift.
    always_comb begin
        adj = acc;
        for (int k = 0; k < ACC_D; k++) begin
            if (acc[4*k +: 4] >= 4'd5)
                adj[4*k +: 4] = acc[4*k +: 4] + 4'd3;
        end
    end

`ifdef BCD_ZERO_BLANK_EN
    localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

    logic [DIGITS-1:0] blank_n;

    // Scan from the top digit down; once a non-zero digit is seen, nothing below is blanked.
    always_comb begin
        logic seen;
        seen    = 1'b0;
        blank_n = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (acc[4*k +: 4] != 4'd0) seen = 1'b1;
            blank_n[k] = ~seen;
        end
    end
`else
    assign blank = '0;
`endif

    always_ff @(posedge clk) begin
        if (resetN) begin
            state    <= IDLE;
            sh       <= '0;
            acc      <= '0;
            cnt      <= '0;
            ovf_r    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            digits   <= '0;
            overflow <= 1'b0;
`ifdef BCD_ZERO_BLANK_EN
            blank    <= BLANK_RST;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sh    <= value;
                        acc   <= '0;
                        cnt   <= '0;
                        ovf_r <= (64'(value) > MAX_DEC);
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc <= {adj[ACC_W-2:0], sh[BIN_W-1]};
                    sh  <= sh << 1;
                    cnt <= cnt + 6'd1;
                    if (cnt == LAST) begin
                        busy  <= 1'b0;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    // Upper acc digits beyond DIGITS are dropped; ovf_r alone decides the clamp.
                    digits   <= ovf_r ? ALL_NINES : acc[DW-1:0];
                    overflow <= ovf_r;
                    done     <= 1'b1;
`ifdef BCD_ZERO_BLANK_EN
                    blank    <= ovf_r ? '0 : blank_n;
`endif
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_score_converter.sv
// Directed self-checking bench for bcd_score_converter (BIN_W=20, DIGITS=6).
// Each task drives one scenario and checks its own results inline.
module tb_bcd_score_converter;

    logic        clk = 1'b0;
    logic        resetN = 1'b1;
    logic [19:0] value = '0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [23:0] digits;
    logic        overflow;
    logic [5:0]  blank;

    int passed = 0;
    int total  = 0;

`ifdef BCD_ZERO_BLANK_EN
    localparam logic [5:0] BL_RST  = 6'b111110;
    localparam logic [5:0] BL_ZERO = 6'b111110;
    localparam logic [5:0] BL_12345 = 6'b100000;
    localparam logic [5:0] BL_500  = 6'b111000;
`else
    localparam logic [5:0] BL_RST  = 6'b000000;
    localparam logic [5:0] BL_ZERO = 6'b000000;
    localparam logic [5:0] BL_12345 = 6'b000000;
    localparam logic [5:0] BL_500  = 6'b000000;
`endif

    bcd_score_converter #(.BIN_W(20), .DIGITS(6)) dut (
        .clk(clk),
        .resetN(resetN),
        .value(value),
        .start(start),
        .busy(busy),
        .done(done),
        .digits(digits),
        .overflow(overflow),
        .blank(blank)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a conversion and returns the number of edges from acceptance to done (0 = timeout).
    task automatic run(input logic [19:0] v, output int lat, output logic busy_e0);
        value = v;
        start = 1'b1;
        tick();
        start = 1'b0;
        busy_e0 = busy;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        resetN = 1'b1;
        tick();
        tick();
        resetN = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
        total++; if (digits !== 24'h0) $display("FAIL reset_digits got %h want 000000", digits); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL reset_ovf got %b want 0", overflow); else passed++;
        total++; if (blank !== BL_RST) $display("FAIL reset_blank got %b want %b", blank, BL_RST); else passed++;
    endtask

    task automatic test_zero();
        int lat; logic b0;
        run(20'd0, lat, b0);
        total++; if (b0 !== 1'b1) $display("FAIL zero_busy_e0 got %b want 1", b0); else passed++;
        total++; if (lat !== 21) $display("FAIL zero_latency got %0d want 21", lat); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL zero_busy_done got %b want 0", busy); else passed++;
        total++; if (digits !== 24'h000000) $display("FAIL zero_digits got %h want 000000", digits); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL zero_ovf got %b want 0", overflow); else passed++;
        total++; if (blank !== BL_ZERO) $display("FAIL zero_blank got %b want %b", blank, BL_ZERO); else passed++;
        tick();
        total++; if (done !== 1'b0) $display("FAIL zero_done_pulse got %b want 0", done); else passed++;
    endtask

    task automatic test_typical();
        int lat; logic b0;
        run(20'd12345, lat, b0);
        total++; if (lat !== 21) $display("FAIL typ_latency got %0d want 21", lat); else passed++;
        total++; if (digits !== 24'h012345) $display("FAIL typ_digits got %h want 012345", digits); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL typ_ovf got %b want 0", overflow); else passed++;
        total++; if (blank !== BL_12345) $display("FAIL typ_blank got %b want %b", blank, BL_12345); else passed++;
        tick();
    endtask

    task automatic test_overflow();
        int lat; logic b0;
        run(20'd1048575, lat, b0);
        total++; if (lat !== 21) $display("FAIL ovf_latency got %0d want 21", lat); else passed++;
        total++; if (digits !== 24'h999999) $display("FAIL ovf_digits got %h want 999999", digits); else passed++;
        total++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %b want 1", overflow); else passed++;
        total++; if (blank !== 6'b0) $display("FAIL ovf_blank got %b want 000000", blank); else passed++;
        tick();
        run(20'd1000000, lat, b0);
        total++; if (digits !== 24'h999999) $display("FAIL ovf_edge_digits got %h want 999999", digits); else passed++;
        total++; if (overflow !== 1'b1) $display("FAIL ovf_edge_flag got %b want 1", overflow); else passed++;
        tick();
    endtask

    task automatic test_back_to_back();
        int first; int second;
        first = 0;
        second = 0;
        value = 20'd999999;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            start = 1'b0;
            if (n == 5) begin
                value = 20'd7;
                start = 1'b1;
            end
            if (n == 10 && digits !== 24'h999999 && first == 0) begin
                // prior overflow result must still be held mid-conversion
                total++;
                $display("FAIL b2b_hold got %h want 999999", digits);
            end else if (n == 10) begin
                total++; passed++;
            end
            tick();
            if (done) begin
                if (first == 0) begin
                    first = n;
                    total++; if (digits !== 24'h999999) $display("FAIL b2b_first_digits got %h want 999999", digits); else passed++;
                    total++; if (overflow !== 1'b0) $display("FAIL b2b_first_ovf got %b want 0", overflow); else passed++;
                    value = 20'd7;
                    start = 1'b1;
                    tick();
                    start = 1'b0;
                    n++;
                end else begin
                    second = n;
                    break;
                end
            end
        end
        start = 1'b0;
        total++; if (first !== 21) $display("FAIL b2b_first_lat got %0d want 21", first); else passed++;
        total++; if (second !== 43) $display("FAIL b2b_second_lat got %0d want 43", second); else passed++;
        total++; if (digits !== 24'h000007) $display("FAIL b2b_second_digits got %h want 000007", digits); else passed++;
        tick();
    endtask

    task automatic test_reset_abort();
        int lat; int pulses; logic b0;
        run(20'd500, lat, b0);
        total++; if (digits !== 24'h000500) $display("FAIL abort_pre_digits got %h want 000500", digits); else passed++;
        total++; if (blank !== BL_500) $display("FAIL abort_pre_blank got %b want %b", blank, BL_500); else passed++;
        tick();
        value = 20'd77;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 9; n++) tick();
        resetN = 1'b1;
        tick();
        resetN = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL abort_done got %b want 0", done); else passed++;
        total++; if (digits !== 24'h0) $display("FAIL abort_digits got %h want 000000", digits); else passed++;
        total++; if (blank !== BL_RST) $display("FAIL abort_blank got %b want %b", blank, BL_RST); else passed++;
        pulses = 0;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (done) pulses++;
        end
        total++; if (pulses !== 0) $display("FAIL abort_no_done got %0d want 0", pulses); else passed++;
        run(20'd42, lat, b0);
        total++; if (lat !== 21) $display("FAIL abort_next_lat got %0d want 21", lat); else passed++;
        total++; if (digits !== 24'h000042) $display("FAIL abort_next_digits got %h want 000042", digits); else passed++;
        tick();
    endtask

    initial begin
        test_reset();
        test_zero();
        test_typical();
        test_overflow();
        test_back_to_back();
        test_reset_abort();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
